// File: rtl/jk_count_ctrl_pkg.sv
// Shared definitions for the JK-cell counter controller: command opcodes,
// FSM state encoding and a small opcode helper used by the controller.
package jk_ctrl_pkg;

  // Command opcodes carried on cmd_op
  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_CPL  = 2'b11;

  // Controller sequencing states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // UP and DOWN take their step count from cmd_data; LOAD and CPL are single-step
  function automatic logic isStepOp(input logic [1:0] op);
    return (op == OP_UP) || (op == OP_DOWN);
  endfunction

endpackage

// File: rtl/jk_count_ctrl_if.sv
// Command handshake plus status/observability bundle for jk_count_ctrl.
// The master side issues commands; the slave side is the controller.
interface jk_count_ctrl_if #(
  parameter int WIDTH = 4
);

  logic             cmd_valid;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] j_o;
  logic [WIDTH-1:0] k_o;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, busy, done, q, j_o, k_o
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, busy, done, q, j_o, k_o
  );

endinterface

// File: rtl/jk_count_ctrl_cell.sv
// Single JK flip-flop storage cell with synchronous active-high reset.
// One of these per register bit; the controller supplies all J/K drive.
module jk_cell (
  input  logic CLK,
  input  logic RST,
  input  logic i_j,
  input  logic i_k,
  output logic o_q
);

  logic r_q;

  // JK behaviour: 00 hold, 01 clear, 10 set, 11 toggle
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q <= 1'b0;
    end else begin
      case ({i_j, i_k})
        2'b01:   r_q <= 1'b0;
        2'b10:   r_q <= 1'b1;
        2'b11:   r_q <= ~r_q;
        default: r_q <= r_q;
      endcase
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/jk_count_ctrl.sv
// Sequencing controller for a WIDTH-bit register made of JK cells.
// Accepts LOAD / UP N / DOWN N / CPL commands one at a time and turns each
// into a run of per-bit J/K excitations, one step per clock, then pulses done.
// The register value exists only inside the JK cell bank.
module jk_count_ctrl
  import jk_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic            CLK,
  input  logic            RST,
  jk_count_ctrl_if.slave  bus
);

  localparam logic [WIDTH-1:0] REM_ONE = WIDTH'(1);

  state_t           r_state;
  state_t           w_nextState;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_arg;
  logic [WIDTH-1:0] r_rem;

  logic             w_accept;
  logic             w_zeroStep;
  logic             w_lastStep;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic [WIDTH-1:0] w_tUp;
  logic [WIDTH-1:0] w_tDown;

  // A command is taken only while idle; a zero-length UP/DOWN skips RUN entirely
  assign w_accept   = bus.cmd_valid && (r_state == ST_IDLE);
  assign w_zeroStep = isStepOp(bus.cmd_op) && (bus.cmd_data == '0);
  assign w_lastStep = (r_state == ST_RUN) && (r_rem == REM_ONE);

  // State register; reset aborts any command in flight
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: IDLE -> RUN/DONE on accept, RUN -> DONE on last step, DONE lasts one cycle
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_nextState = w_zeroStep ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_lastStep) begin
          w_nextState = ST_DONE;
        end
      end
      ST_DONE: begin
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Capture the command at the accept edge so later bus changes cannot disturb it
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_op  <= OP_LOAD;
      r_arg <= '0;
    end else if (w_accept) begin
      r_op  <= bus.cmd_op;
      r_arg <= bus.cmd_data;
    end
  end

  // Remaining-step counter: N for UP/DOWN, one step for LOAD/CPL, counts down in RUN
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rem <= '0;
    end else if (w_accept) begin
      r_rem <= isStepOp(bus.cmd_op) ? bus.cmd_data : REM_ONE;
    end else if (r_state == ST_RUN) begin
      r_rem <= r_rem - REM_ONE;
    end
  end

  // Ripple toggle enables: bit i toggles when all lower bits are 1 (up) or all 0 (down)
  always_comb begin : toggleTerms
    logic upAcc;
    logic downAcc;
    upAcc   = 1'b1;
    downAcc = 1'b1;
    w_tUp   = '0;
    w_tDown = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_tUp[i]   = upAcc;
      w_tDown[i] = downAcc;
      upAcc      = upAcc & w_q[i];
      downAcc    = downAcc & ~w_q[i];
    end
  end

  // J/K excitation per opcode; outside RUN every cell holds
  always_comb begin
    w_j = '0;
    w_k = '0;
    if (r_state == ST_RUN) begin
      case (r_op)
        OP_LOAD: begin
          w_j = r_arg;
          w_k = ~r_arg;
        end
        OP_UP: begin
          w_j = w_tUp;
          w_k = w_tUp;
        end
        OP_DOWN: begin
          w_j = w_tDown;
          w_k = w_tDown;
        end
        default: begin
          w_j = '1;
          w_k = '1;
        end
      endcase
    end
  end

  // The register itself: one JK cell per bit
  for (genvar g = 0; g < WIDTH; g++) begin : gCells
    jk_cell uCell (
      .CLK (CLK),
      .RST (RST),
      .i_j (w_j[g]),
      .i_k (w_k[g]),
      .o_q (w_q[g])
    );
  end

  assign bus.cmd_ready = (r_state == ST_IDLE);
  assign bus.busy      = (r_state == ST_RUN);
  assign bus.done      = (r_state == ST_DONE);
  assign bus.q         = w_q;
  assign bus.j_o       = w_j;
  assign bus.k_o       = w_k;

endmodule

// File: tb/tb_jk_count_ctrl.sv
// Directed bench for jk_count_ctrl: hand-computed register values and
// handshake timing for LOAD, CPL, UP/DOWN with wrap, zero-length steps,
// mid-run reset abort and a command held valid across a busy period.
module tb_jk_count_ctrl;
  import jk_ctrl_pkg::*;

  localparam int WIDTH = 4;

  logic clk;
  logic rst;
  int   totalChecks;
  int   badChecks;
  int   cyc;

  jk_count_ctrl_if #(.WIDTH(WIDTH)) bus ();

  jk_count_ctrl #(.WIDTH(WIDTH)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges the stimulus thread
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before end of test");
    $fatal(1, "[TB] watchdog");
  end

  // Compare one observed value against its expected value and tally the result
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Drive the command bus
  task automatic applyStimulus(input logic valid, input logic [1:0] op,
                               input logic [WIDTH-1:0] data);
    bus.cmd_valid = valid;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
  endtask

  // Present a command for exactly one accept edge, then withdraw it
  task automatic sendCmd(input logic [1:0] op, input logic [WIDTH-1:0] data);
    applyStimulus(1'b1, op, data);
    stepCycle();
    applyStimulus(1'b0, OP_LOAD, '0);
  endtask

  // Count cycles after the accept edge until done is seen (bounded)
  task automatic waitDone(output int cycles);
    cycles = 0;
    while (!bus.done && cycles < 40) begin
      stepCycle();
      cycles++;
    end
  endtask

  // Full command: send, check step count and final value, then check ready returns
  task automatic runCmd(input string tag, input logic [1:0] op,
                        input logic [WIDTH-1:0] data, input int steps,
                        input logic [WIDTH-1:0] expQ);
    sendCmd(op, data);
    waitDone(cyc);
    checkOutput({tag, "_steps"}, cyc, steps);
    checkOutput({tag, "_q"}, bus.q, expQ);
    stepCycle();
    checkOutput({tag, "_ready"}, bus.cmd_ready, 1);
    checkOutput({tag, "_doneLow"}, bus.done, 0);
  endtask

  initial begin
    totalChecks = 0;
    badChecks   = 0;
    rst = 1'b1;
    applyStimulus(1'b1, OP_LOAD, 4'b1111);

    // Reset held with a command offered: nothing must be accepted
    stepCycle();
    stepCycle();
    checkOutput("rst_q", bus.q, 4'b0000);
    checkOutput("rst_ready", bus.cmd_ready, 1);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_j", bus.j_o, 4'b0000);
    rst = 1'b0;
    applyStimulus(1'b0, OP_LOAD, '0);
    stepCycle();
    checkOutput("postRst_q", bus.q, 4'b0000);

    // LOAD then CPL, with handshake flags right after accept
    sendCmd(OP_LOAD, 4'b1010);
    checkOutput("load_busy", bus.busy, 1);
    checkOutput("load_notReady", bus.cmd_ready, 0);
    checkOutput("load_j", bus.j_o, 4'b1010);
    checkOutput("load_k", bus.k_o, 4'b0101);
    waitDone(cyc);
    checkOutput("load_steps", cyc, 1);
    checkOutput("load_q", bus.q, 4'b1010);
    checkOutput("load_doneNotBusy", bus.busy, 0);
    stepCycle();
    checkOutput("load_ready", bus.cmd_ready, 1);
    runCmd("cpl", OP_CPL, 4'b0110, 1, 4'b0101);

    // LOAD 1110 then UP 3, stepping by hand through the wrap
    runCmd("load1110", OP_LOAD, 4'b1110, 1, 4'b1110);
    sendCmd(OP_UP, 4'd3);
    checkOutput("up_j0", bus.j_o, 4'b0001);
    stepCycle();
    checkOutput("up_q1", bus.q, 4'b1111);
    checkOutput("up_jWrap", bus.j_o, 4'b1111);
    checkOutput("up_kWrap", bus.k_o, 4'b1111);
    stepCycle();
    checkOutput("up_q2", bus.q, 4'b0000);
    checkOutput("up_notDone2", bus.done, 0);
    stepCycle();
    checkOutput("up_q3", bus.q, 4'b0001);
    checkOutput("up_done", bus.done, 1);
    checkOutput("up_doneJ", bus.j_o, 4'b0000);
    stepCycle();
    checkOutput("up_ready", bus.cmd_ready, 1);

    // LOAD 0001, DOWN 2 wraps through zero; then a zero-length UP
    runCmd("load0001", OP_LOAD, 4'b0001, 1, 4'b0001);
    sendCmd(OP_DOWN, 4'd2);
    checkOutput("down_j0", bus.j_o, 4'b0001);
    stepCycle();
    checkOutput("down_q1", bus.q, 4'b0000);
    checkOutput("down_jWrap", bus.j_o, 4'b1111);
    waitDone(cyc);
    checkOutput("down_steps", cyc, 1);
    checkOutput("down_q2", bus.q, 4'b1111);
    stepCycle();
    runCmd("up0", OP_UP, 4'd0, 0, 4'b1111);

    // Reset during the second step of UP 5 aborts with no done pulse
    sendCmd(OP_UP, 4'd5);
    stepCycle();
    checkOutput("abort_q1", bus.q, 4'b0000);
    rst = 1'b1;
    stepCycle();
    checkOutput("abort_q", bus.q, 4'b0000);
    checkOutput("abort_ready", bus.cmd_ready, 1);
    checkOutput("abort_busy", bus.busy, 0);
    checkOutput("abort_done", bus.done, 0);
    rst = 1'b0;
    stepCycle();
    checkOutput("abort_stillIdle", bus.done, 0);
    checkOutput("abort_qHeld", bus.q, 4'b0000);
    runCmd("load0011", OP_LOAD, 4'b0011, 1, 4'b0011);

    // Maximum step count: 3 + 15 wraps to 2
    runCmd("up15", OP_UP, 4'd15, 15, 4'b0010);

    // Command held valid while data changes: only the first runs until DONE ends
    applyStimulus(1'b1, OP_LOAD, 4'b0110);
    stepCycle();
    applyStimulus(1'b1, OP_LOAD, 4'b1001);
    stepCycle();
    checkOutput("hold_q", bus.q, 4'b0110);
    checkOutput("hold_done", bus.done, 1);
    applyStimulus(1'b1, OP_LOAD, 4'b1100);
    stepCycle();
    checkOutput("hold_idle", bus.cmd_ready, 1);
    checkOutput("hold_qKept", bus.q, 4'b0110);
    stepCycle();
    checkOutput("hold_accept", bus.busy, 1);
    applyStimulus(1'b0, OP_LOAD, '0);
    waitDone(cyc);
    checkOutput("hold_steps", cyc, 1);
    checkOutput("hold_q2", bus.q, 4'b1100);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
